// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the grant/done handshake, the result and
// the shared-ALU operand/result path between the arbiter and its environment.
interface alu_arbiter_if;
  logic        req0;
  logic [7:0]  opA0;
  logic [7:0]  opB0;
  logic        op0;
  logic        req1;
  logic [7:0]  opA1;
  logic [7:0]  opB1;
  logic        op1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] res;
  logic        busy;
  logic [7:0]  alu_opA;
  logic [7:0]  alu_opB;
  logic        alu_opcode;
  logic [15:0] alu_res;

  // Handshake: a requester raises reqN with stable operands and holds it until
  // gntN pulses; gntN means operands were latched, doneN means res is valid
  // for that requester. Both gnt and done are single-cycle pulses.
  modport slave (
    input  req0, opA0, opB0, op0,
    input  req1, opA1, opB1, op1,
    input  alu_res,
    output gnt0, gnt1, done0, done1, res, busy,
    output alu_opA, alu_opB, alu_opcode
  );

  modport master (
    output req0, opA0, opB0, op0,
    output req1, opA1, opB1, op1,
    output alu_res,
    input  gnt0, gnt1, done0, done1, res, busy,
    input  alu_opA, alu_opB, alu_opcode
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU; one operation
// in flight, IDLE -> EXEC -> DONE, round-robin or fixed-priority selection.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   last_srv;  // 1 = requester 1 was served last
  logic   winner;    // requester owning the transaction in flight
  logic   pick;

  assign state_dbg = state;

  // With only one requester active it wins regardless of the pointer.
  always_comb begin
    pick = 1'b0;
    if (RR_EN) begin
      if (bus.req0 && bus.req1) pick = ~last_srv;
      else                      pick = bus.req1;
    end else begin
      pick = ~bus.req0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_srv       <= 1'b1;
      winner         <= 1'b0;
      bus.gnt0       <= 1'b0;
      bus.gnt1       <= 1'b0;
      bus.done0      <= 1'b0;
      bus.done1      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.res        <= 16'h0000;
      bus.alu_opA    <= 8'h00;
      bus.alu_opB    <= 8'h00;
      bus.alu_opcode <= 1'b0;
    end else begin
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (bus.req0 || bus.req1) begin
            state    <= EXEC;
            bus.busy <= 1'b1;
            winner   <= pick;
            last_srv <= pick;
            bus.gnt0 <= ~pick;
            bus.gnt1 <= pick;
            if (pick) begin
              bus.alu_opA    <= bus.opA1;
              bus.alu_opB    <= bus.opB1;
              bus.alu_opcode <= bus.op1;
            end else begin
              bus.alu_opA    <= bus.opA0;
              bus.alu_opB    <= bus.opB0;
              bus.alu_opcode <= bus.op0;
            end
          end
        end
        EXEC: begin
          state     <= DONE;
          bus.busy  <= 1'b1;
          bus.res   <= bus.alu_res;
          bus.done0 <= ~winner;
          bus.done1 <= winner;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority
// instance share clock and reset; each sees a behavioural ALU.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] st_rr;
  logic [1:0] st_fp;
  int         total = 0;
  int         bad   = 0;

  alu_arbiter_if bus_rr ();
  alu_arbiter_if bus_fp ();

  alu_arbiter #(.RR_EN(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(bus_rr.slave), .state_dbg(st_rr));
  alu_arbiter #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(bus_fp.slave), .state_dbg(st_fp));

  // Shared-ALU model: 8x8 multiply or zero-extended add, full 16-bit result.
  assign bus_rr.alu_res = bus_rr.alu_opcode ? (16'(bus_rr.alu_opA) * 16'(bus_rr.alu_opB))
                                            : (16'(bus_rr.alu_opA) + 16'(bus_rr.alu_opB));
  assign bus_fp.alu_res = bus_fp.alu_opcode ? (16'(bus_fp.alu_opA) * 16'(bus_fp.alu_opB))
                                            : (16'(bus_fp.alu_opA) + 16'(bus_fp.alu_opB));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Mutual exclusion of grants and dones, checked on every falling edge.
  always @(negedge clk) begin
    chk("rr_gnt_excl",  16'(bus_rr.gnt0 & bus_rr.gnt1), 16'h0);
    chk("rr_done_excl", 16'(bus_rr.done0 & bus_rr.done1), 16'h0);
    chk("fp_gnt_excl",  16'(bus_fp.gnt0 & bus_fp.gnt1), 16'h0);
  end

  task automatic rr_pulses(input string tag, input logic g0, input logic g1,
                           input logic d0, input logic d1, input logic bz);
    chk({tag, "_gnt0"},  16'(bus_rr.gnt0),  16'(g0));
    chk({tag, "_gnt1"},  16'(bus_rr.gnt1),  16'(g1));
    chk({tag, "_done0"}, 16'(bus_rr.done0), 16'(d0));
    chk({tag, "_done1"}, 16'(bus_rr.done1), 16'(d1));
    chk({tag, "_busy"},  16'(bus_rr.busy),  16'(bz));
  endtask

  task automatic rr_reset_vals(input string tag);
    rr_pulses(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_res"},    bus_rr.res, 16'h0000);
    chk({tag, "_opA"},    16'(bus_rr.alu_opA), 16'h0);
    chk({tag, "_opB"},    16'(bus_rr.alu_opB), 16'h0);
    chk({tag, "_opcode"}, 16'(bus_rr.alu_opcode), 16'h0);
    chk({tag, "_state"},  16'(st_rr), 16'h0);
  endtask

  initial begin
    {bus_rr.req0, bus_rr.opA0, bus_rr.opB0, bus_rr.op0} = '0;
    {bus_rr.req1, bus_rr.opA1, bus_rr.opB1, bus_rr.op1} = '0;
    {bus_fp.req0, bus_fp.opA0, bus_fp.opB0, bus_fp.op0} = '0;
    {bus_fp.req1, bus_fp.opA1, bus_fp.opB1, bus_fp.op1} = '0;

    // Reset state
    cyc(); cyc();
    rr_reset_vals("rst");
    chk("rst_fp_busy", 16'(bus_fp.busy), 16'h0);
    rst = 1'b0;

    // Single add from requester 0: 3 + 5
    bus_rr.req0 = 1'b1; bus_rr.opA0 = 8'd3; bus_rr.opB0 = 8'd5; bus_rr.op0 = 1'b0;
    cyc();
    rr_pulses("add_n1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("add_n1_opA", 16'(bus_rr.alu_opA), 16'd3);
    chk("add_n1_opB", 16'(bus_rr.alu_opB), 16'd5);
    chk("add_n1_state", 16'(st_rr), 16'd1);
    bus_rr.req0 = 1'b0;
    cyc();
    rr_pulses("add_n2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("add_n2_res", bus_rr.res, 16'd8);
    cyc();
    rr_pulses("add_n3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_n3_res_hold", bus_rr.res, 16'd8);

    // Single multiply from requester 1: FF * FF
    bus_rr.req1 = 1'b1; bus_rr.opA1 = 8'hFF; bus_rr.opB1 = 8'hFF; bus_rr.op1 = 1'b1;
    cyc();
    rr_pulses("mul_n1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mul_n1_opcode", 16'(bus_rr.alu_opcode), 16'h1);
    bus_rr.req1 = 1'b0;
    cyc();
    rr_pulses("mul_n2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mul_n2_res", bus_rr.res, 16'hFE01);
    cyc();
    rr_pulses("mul_n3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh reset, then a held tie: service must go 0,1,0,1
    rst = 1'b1; cyc(); rst = 1'b0;
    bus_rr.req0 = 1'b1; bus_rr.opA0 = 8'hFF; bus_rr.opB0 = 8'h01; bus_rr.op0 = 1'b0;
    bus_rr.req1 = 1'b1; bus_rr.opA1 = 8'd12; bus_rr.opB1 = 8'd10; bus_rr.op1 = 1'b1;
    cyc(); rr_pulses("tie_g0a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); rr_pulses("tie_d0a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("tie_res0", bus_rr.res, 16'h0100);
    cyc(); rr_pulses("tie_idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); rr_pulses("tie_g1a", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(); rr_pulses("tie_d1a", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("tie_res1", bus_rr.res, 16'd120);
    cyc();
    cyc(); rr_pulses("tie_g0b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); cyc();
    cyc(); rr_pulses("tie_g1b", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus_rr.req0 = 1'b0; bus_rr.req1 = 1'b0;
    cyc(); chk("tie_res1b", bus_rr.res, 16'd120);
    cyc();

    // Operand change after grant must not affect the result: 2 + 3
    bus_rr.req0 = 1'b1; bus_rr.opA0 = 8'd2; bus_rr.opB0 = 8'd3; bus_rr.op0 = 1'b0;
    cyc(); rr_pulses("opchg_g", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_rr.opA0 = 8'd9; bus_rr.req0 = 1'b0;
    cyc(); rr_pulses("opchg_d", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("opchg_res", bus_rr.res, 16'd5);
    chk("opchg_opA_stable", 16'(bus_rr.alu_opA), 16'd2);
    cyc();

    // Reset during EXEC aborts the transaction
    bus_rr.req0 = 1'b1; bus_rr.opA0 = 8'd7; bus_rr.opB0 = 8'd7; bus_rr.op0 = 1'b1;
    cyc(); rr_pulses("abort_g", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; bus_rr.req0 = 1'b0;
    cyc(); rr_reset_vals("abort_rst");
    rst = 1'b0;
    cyc(); rr_reset_vals("abort_after");

    // Request held through reset is served on the first edge after release
    rst = 1'b1;
    bus_rr.req1 = 1'b1; bus_rr.opA1 = 8'd4; bus_rr.opB1 = 8'd4; bus_rr.op1 = 1'b0;
    cyc(); rr_pulses("rstreq_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(); rr_pulses("rstreq_g", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus_rr.req1 = 1'b0;
    cyc(); rr_pulses("rstreq_d", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rstreq_res", bus_rr.res, 16'd8);
    cyc();

    // Fixed priority: requester 0 keeps winning while held
    bus_fp.req0 = 1'b1; bus_fp.opA0 = 8'd1; bus_fp.opB0 = 8'd1; bus_fp.op0 = 1'b0;
    bus_fp.req1 = 1'b1; bus_fp.opA1 = 8'd2; bus_fp.opB1 = 8'd2; bus_fp.op1 = 1'b0;
    cyc(); chk("fp_g0a", 16'(bus_fp.gnt0), 16'h1); chk("fp_g1a", 16'(bus_fp.gnt1), 16'h0);
    cyc(); chk("fp_d0a", 16'(bus_fp.done0), 16'h1); chk("fp_res0a", bus_fp.res, 16'd2);
    cyc();
    cyc(); chk("fp_g0b", 16'(bus_fp.gnt0), 16'h1); chk("fp_g1b", 16'(bus_fp.gnt1), 16'h0);
    bus_fp.req0 = 1'b0;
    cyc(); chk("fp_d0b", 16'(bus_fp.done0), 16'h1); chk("fp_d1b", 16'(bus_fp.done1), 16'h0);
    cyc();
    cyc(); chk("fp_g1c", 16'(bus_fp.gnt1), 16'h1); chk("fp_g0c", 16'(bus_fp.gnt0), 16'h0);
    bus_fp.req1 = 1'b0;
    cyc(); chk("fp_d1c", 16'(bus_fp.done1), 16'h1); chk("fp_res1c", bus_fp.res, 16'd4);
    cyc(); chk("fp_idle", 16'(bus_fp.busy), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 winning.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 request; held high until gnt0 is seen.
REQ-005 opA0, opB0  input  8 each  requester 0 operands.
REQ-006 op0  input  1  requester 0 opcode: 0 = add, 1 = multiply.
REQ-007 req1, opA1, opB1, op1  input  1/8/8/1  requester 1 equivalents.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted and operands latched.
REQ-009 done0, done1  output  1 each  one-cycle pulse: res holds that requester's result.
REQ-010 res  output  16  registered result.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 alu_opA, alu_opB  output  8 each  registered operands to the shared ALU.
REQ-013 alu_opcode  output  1  registered opcode to the shared ALU.
REQ-014 alu_res  input  16  combinational ALU result.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and DONE, with one transaction in flight at most.
REQ-016 IDLE: no req -> stay in IDLE; any req -> select a winner, latch its opA/opB/opcode into alu_opA/alu_opB/alu_opcode, and go to EXEC.
REQ-017 EXEC: gnt of the winner SHALL be 1 for exactly this cycle; alu_res is captured into res on the exit edge; next state is DONE.
REQ-018 DONE: done of the winner SHALL be 1 for exactly this cycle, with res valid; next state is IDLE.
REQ-019 Latency: req sampled high in IDLE at edge N -> gnt in cycle N+1 -> done in cycle N+2 -> IDLE again in cycle N+3, so throughput is at most one operation per 3 cycles.
REQ-020 Requests SHALL be sampled only in IDLE; req and operand changes in EXEC or DONE SHALL be ignored.
REQ-021 Round-robin (RR_EN=1) SHALL use a last-served pointer: when both requesters are high, grant the one not served last; when only one is high, grant it regardless of the pointer.
REQ-022 The pointer SHALL update only when a grant is issued.
REQ-023 Fixed priority (RR_EN=0): req0 SHALL always win over req1.
REQ-024 A requester still holding req high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-025 res SHALL hold its value until the next EXEC capture; a 16-bit result SHALL never be truncated.
REQ-026 The two gnt outputs SHALL never be high in the same cycle, and the two done outputs SHALL never be high in the same cycle.
REQ-027 alu_opA/alu_opB/alu_opcode SHALL remain stable from EXEC through DONE.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL load: state = IDLE; gnt0/1, done0/1 and busy = 0; res = 16'h0000; alu_opA = alu_opB = 8'h00; alu_opcode = 0; last-served pointer = requester 1, so requester 0 wins the first tie.
REQ-029 A reset asserted in EXEC or DONE SHALL abort the transaction with no done pulse and no res update after reset.
REQ-030 A req that is high during reset SHALL be evaluated in the first IDLE cycle after rst falls.

Verification
REQ-031 req0=1, opA0=8'd3, opB0=8'd5, op0=0 -> gnt0 at N+1, done0 at N+2, res=16'd8, busy high for 2 cycles.
REQ-032 req1=1, opA1=8'hFF, opB1=8'hFF, op1=1 -> gnt1, then done1 with res=16'hFE01; gnt0 and done0 stay 0.
REQ-033 First tie after reset, with RR_EN=1, req0 (add 8'hFF+8'h01) and req1 (mul 8'd12*8'd10) both held -> done0 with res=16'h0100 first, then done1 with res=16'd120; both continuing to hold req -> service alternates 0,1,0,1.
REQ-034 RR_EN=0, both requesters held continuously -> only requester 0 is ever granted; requester 1 is granted only after req0 drops.
REQ-035 rst pulsed in EXEC (gnt0=1) -> next cycle IDLE, no done0, res=16'h0000, all outputs at reset values.
REQ-036 Operand change during EXEC (opA0 switched from 8'd2 to 8'd9 after gnt0) -> res reflects 8'd2.
